mole_scheduler: RTL and testbench

Round sequencer for the whack-a-mole game. It decides when and where each mole appears, how long it stays up, and when the round ends. It scores hits, counts misses, and shortens the mole on-time after every hit. It sits between the debounced push-button front end (`hit`) and the LED and score-display logic (`mole_led`, `score`).

---
 rtl/mole_pkg.sv | 23 ++
 rtl/mole_lfsr.sv | 27 ++
 rtl/mole_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_mole_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// mole_pkg: shared types and constants for the whack-a-mole round sequencer.
package mole_pkg;

    // Round sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        UP   = 2'd2,
        OVER = 2'd3
    } mole_state_t;

    // Feedback taps 8,6,5,4 of the 8-bit Fibonacci LFSR (bit 7 is tap 8)
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Score and miss counters saturate here (two-digit display)
    localparam logic [6:0] SCORE_MAX = 7'd99;

    // Saturating increment for the two-digit counters
    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        return (v < SCORE_MAX) ? v + 7'd1 : v;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// mole_lfsr: free-running 8-bit Fibonacci LFSR, shifts every cycle.
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       cin,
    input  logic       rst_n,
    output logic [7:0] o_lfsr
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb   = ^(r_lfsr & LFSR_TAPS);
    assign o_lfsr = r_lfsr;

    // Shift left, feedback enters at bit 0; never stalls so start timing perturbs it
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole round sequencer (mole placement, timing, scoring).
// Optional build macro WRONG_HIT_PENALTY_EN: a wrong-hole press during UP
// counts as a miss and ends the current mole.
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int unsigned N_HOLES       = 9,
    parameter int unsigned ON_TIME_START = 100_000_000,
    parameter int unsigned ON_TIME_MIN   = 20_000_000,
    parameter int unsigned ON_TIME_STEP  = 2_500_000,
    parameter int unsigned GAP_CYCLES    = 12_500_000,
    parameter int unsigned ROUND_MOLES   = 30,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic               cin,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_HOLES-1:0] hit,
    output logic [N_HOLES-1:0] mole_led,
    output logic [6:0]         score,
    output logic [6:0]         misses,
    output logic               score_inc,
    output logic               busy,
    output logic               game_over
);

    // Registered state
    mole_state_t        r_state;
    logic [31:0]        r_timer;
    logic [31:0]        r_on_time;
    logic [31:0]        r_mole_cnt;
    logic [3:0]         r_hole;
    logic [N_HOLES-1:0] r_mole_led;
    logic [6:0]         r_score;
    logic [6:0]         r_misses;
    logic               r_score_inc;
    logic               r_busy;
    logic               r_game_over;

    // Next-state values
    mole_state_t        w_state_next;
    logic [31:0]        w_timer_next;
    logic [31:0]        w_on_time_next;
    logic [31:0]        w_mole_cnt_next;
    logic [3:0]         w_hole_next;
    logic [N_HOLES-1:0] w_mole_led_next;
    logic [6:0]         w_score_next;
    logic [6:0]         w_misses_next;
    logic               w_score_inc_next;
    logic               w_busy_next;
    logic               w_game_over_next;

    // Combinational helpers
    logic [7:0]         w_lfsr;
    logic [3:0]         w_cand;
    logic [3:0]         w_sel;
    logic [N_HOLES-1:0] w_hit_match;
    logic               w_hit_ok;
    logic               w_penalty;
    logic               w_gap_expire;
    logic               w_up_expire;
    logic [31:0]        w_on_time_dec;
    logic [31:0]        w_mole_cnt_inc;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .cin    (cin),
        .rst_n  (rst_n),
        .o_lfsr (w_lfsr)
    );

    // Hole pick: LFSR modulo hole count, bumped by one if it would repeat
    assign w_cand = 4'(w_lfsr % 8'(N_HOLES));
    assign w_sel  = (w_cand != r_hole)                ? w_cand :
                    (w_cand == 4'(N_HOLES - 1))       ? 4'd0   :
                                                        w_cand + 4'd1;

    // mole_led is one-hot on the active hole during UP, so a per-hole AND finds the hit
    genvar gi;
    generate
        for (gi = 0; gi < N_HOLES; gi++) begin : g_hit
            assign w_hit_match[gi] = hit[gi] & r_mole_led[gi];
        end
    endgenerate
    assign w_hit_ok = |w_hit_match;

`ifdef WRONG_HIT_PENALTY_EN
    assign w_penalty = |(hit & ~r_mole_led);
`else
    assign w_penalty = 1'b0;
`endif

    assign w_gap_expire   = (r_timer == GAP_CYCLES - 32'd1);
    assign w_up_expire    = (r_timer == r_on_time - 32'd1);
    // Clamp at the floor instead of subtracting past it
    assign w_on_time_dec  = (r_on_time >= ON_TIME_MIN + ON_TIME_STEP) ?
                            r_on_time - ON_TIME_STEP : ON_TIME_MIN;
    assign w_mole_cnt_inc = r_mole_cnt + 32'd1;

    // Next-state and registered-output logic; a correct hit beats expiry and wrong hits
    always_comb begin
        w_state_next     = r_state;
        w_timer_next     = r_timer;
        w_on_time_next   = r_on_time;
        w_mole_cnt_next  = r_mole_cnt;
        w_hole_next      = r_hole;
        w_mole_led_next  = r_mole_led;
        w_score_next     = r_score;
        w_misses_next    = r_misses;
        w_score_inc_next = 1'b0;
        w_busy_next      = r_busy;
        w_game_over_next = r_game_over;

        case (r_state)
            IDLE, OVER: begin
                if (start) begin
                    w_state_next     = GAP;
                    w_timer_next     = '0;
                    w_on_time_next   = ON_TIME_START;
                    w_mole_cnt_next  = '0;
                    w_mole_led_next  = '0;
                    w_score_next     = '0;
                    w_misses_next    = '0;
                    w_busy_next      = 1'b1;
                    w_game_over_next = 1'b0;
                end
            end
            GAP: begin
                if (w_gap_expire) begin
                    w_state_next    = UP;
                    w_timer_next    = '0;
                    w_hole_next     = w_sel;
                    w_mole_led_next = {{(N_HOLES-1){1'b0}}, 1'b1} << w_sel;
                end else begin
                    w_timer_next = r_timer + 32'd1;
                end
            end
            UP: begin
                if (w_hit_ok || w_up_expire || w_penalty) begin
                    if (w_hit_ok) begin
                        w_score_next     = sat_inc(r_score);
                        w_score_inc_next = 1'b1;
                        w_on_time_next   = w_on_time_dec;
                    end else begin
                        w_misses_next = sat_inc(r_misses);
                    end
                    w_timer_next    = '0;
                    w_mole_led_next = '0;
                    w_mole_cnt_next = w_mole_cnt_inc;
                    if (w_mole_cnt_inc == ROUND_MOLES) begin
                        w_state_next     = OVER;
                        w_busy_next      = 1'b0;
                        w_game_over_next = 1'b1;
                    end else begin
                        w_state_next = GAP;
                    end
                end else begin
                    w_timer_next = r_timer + 32'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register plus datapath registers; reset wipes any round in progress
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_on_time   <= ON_TIME_START;
            r_mole_cnt  <= '0;
            r_hole      <= '0;
            r_mole_led  <= '0;
            r_score     <= '0;
            r_misses    <= '0;
            r_score_inc <= 1'b0;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_on_time   <= w_on_time_next;
            r_mole_cnt  <= w_mole_cnt_next;
            r_hole      <= w_hole_next;
            r_mole_led  <= w_mole_led_next;
            r_score     <= w_score_next;
            r_misses    <= w_misses_next;
            r_score_inc <= w_score_inc_next;
            r_busy      <= w_busy_next;
            r_game_over <= w_game_over_next;
        end
    end

    assign mole_led  = r_mole_led;
    assign score     = r_score;
    assign misses    = r_misses;
    assign score_inc = r_score_inc;
    assign busy      = r_busy;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: table-driven rounds with a per-mole scoreboard, plus
// hand-written start timing, async reset and no-repeat sequences.
module tb_mole_scheduler;

    localparam int N     = 9;
    localparam int GAP   = 4;
    localparam int T0    = 20;
    localparam int TMIN  = 8;
    localparam int TSTEP = 5;
    localparam int RM    = 4;
    localparam logic [7:0] SEED = 8'hA5;

    logic         cin = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] hit = '0;
    logic [N-1:0] mole_led;
    logic [6:0]   score;
    logic [6:0]   misses;
    logic         score_inc;
    logic         busy;
    logic         game_over;

    mole_scheduler #(
        .N_HOLES       (N),
        .ON_TIME_START (T0),
        .ON_TIME_MIN   (TMIN),
        .ON_TIME_STEP  (TSTEP),
        .GAP_CYCLES    (GAP),
        .ROUND_MOLES   (RM),
        .LFSR_SEED     (SEED)
    ) dut (
        .cin       (cin),
        .rst_n     (rst_n),
        .start     (start),
        .hit       (hit),
        .mole_led  (mole_led),
        .score     (score),
        .misses    (misses),
        .score_inc (score_inc),
        .busy      (busy),
        .game_over (game_over)
    );

    always #5 cin = ~cin;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int prev_hole = 0;   // model of the design's previous hole
    int last_act = 0;    // hole actually shown last time

    // kind: 0 no press, 1 correct hole, 2 wrong hole, 3 start pulse while up
    typedef struct {
        bit st;
        int kind;
        int hit_at;
        int lit;
        int sc;
        int ms;
        bit inc;
        bit over;
    } vec_t;

    typedef struct {
        int lit;
        int sc;
        int ms;
        bit inc;
        bit over;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[15];

    // Reference LFSR: taps 8,6,5,4; m_prev holds the value before the latest edge
    logic [7:0] m_lfsr;
    logic [7:0] m_prev;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    always @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= SEED;
            m_prev <= SEED;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    always @(posedge cin) begin
        if (score_inc === 1'b1) pulses <= pulses + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_led"},   int'(mole_led),  0);
        check({tag, "_score"}, int'(score),     0);
        check({tag, "_miss"},  int'(misses),    0);
        check({tag, "_inc"},   int'(score_inc), 0);
        check({tag, "_busy"},  int'(busy),      0);
        check({tag, "_over"},  int'(game_over), 0);
    endtask

    // Called at a negedge: pulse start for one cycle and check the cleared round
    task automatic pulse_start();
        start = 1'b1;
        @(posedge cin);
        #1 start = 1'b0;
        @(negedge cin);
        check("start_busy",  int'(busy),      1);
        check("start_over",  int'(game_over), 0);
        check("start_score", int'(score),     0);
        check("start_miss",  int'(misses),    0);
    endtask

    // Called at a negedge with the LEDs dark: wait for the next mole and check it
    task automatic wait_mole();
        int dark = 0;
        int cand;
        int act = -1;
        while (mole_led == '0 && dark < 100) begin
            dark++;
            @(negedge cin);
        end
        check("gap_len", dark, GAP);
        cand = int'(m_prev) % N;
        if (cand == prev_hole) cand = (cand + 1) % N;
        check("mole_led", int'(mole_led), 1 << cand);
        prev_hole = cand;
        for (int b = 0; b < N; b++) if (mole_led[b]) act = b;
        check("no_repeat", int'(act != last_act), 1);
        check("hole_range", int'(act >= 0 && act < N), 1);
        last_act = act;
    endtask

    // Called at the negedge a mole first shows: apply the action, measure lit time
    task automatic run_mole(input int kind, input int hit_at, input exp_t e);
        int lit = 1;
        bit done = 1'b0;
        logic [N-1:0] pat;
        exp_t got;
        sb_q.push_back(e);
        pat = (kind == 2) ? {mole_led[N-2:0], mole_led[N-1]} : mole_led;
        while (!done && lit < 100) begin
            if (lit == hit_at) begin
                if (kind == 3) start = 1'b1;
                else if (kind != 0) hit = pat;
            end
            @(posedge cin);
            #1;
            hit = '0;
            start = 1'b0;
            @(negedge cin);
            if (mole_led == '0) done = 1'b1;
            else lit++;
        end
        got = sb_q.pop_front();
        check("lit_cycles", lit,              got.lit);
        check("score",      int'(score),      got.sc);
        check("misses",     int'(misses),     got.ms);
        check("score_inc",  int'(score_inc),  int'(got.inc));
        check("game_over",  int'(game_over),  int'(got.over));
        check("busy",       int'(busy),       int'(!got.over));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_pulses = 0;
        exp_t e;

        // Round 1: all misses, start ignored while up
        vecs[0]  = '{1'b1, 0, 0, 20, 0, 1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3, 5, 20, 0, 2, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 0, 0, 20, 0, 3, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 0, 0, 20, 0, 4, 1'b0, 1'b1};
        // Round 2: every mole hit two cycles after it shows
        vecs[4]  = '{1'b1, 1, 3, 3, 1, 0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1, 3, 3, 2, 0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1, 3, 3, 3, 0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1, 3, 3, 4, 0, 1'b1, 1'b1};
        // Round 3: on-time 20 -> 15 -> 10 -> 8, hits on the expiry cycle win
        vecs[8]  = '{1'b1, 1, 3, 3, 1, 0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1, 15, 15, 2, 0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1, 10, 10, 3, 0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 0, 0, 8, 3, 1, 1'b0, 1'b1};
        // Round 4: wrong-hole press, then two hits (reset follows on mole 4)
`ifdef WRONG_HIT_PENALTY_EN
        vecs[12] = '{1'b1, 2, 3, 3, 0, 1, 1'b0, 1'b0};
`else
        vecs[12] = '{1'b1, 2, 3, 20, 0, 1, 1'b0, 1'b0};
`endif
        vecs[13] = '{1'b0, 1, 2, 2, 1, 1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1, 2, 2, 2, 1, 1'b1, 1'b0};

        foreach (vecs[i]) if (vecs[i].kind == 1) exp_pulses++;

        repeat (3) @(negedge cin);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge cin);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].st) pulse_start();
            wait_mole();
            e = '{vecs[i].lit, vecs[i].sc, vecs[i].ms, vecs[i].inc, vecs[i].over};
            run_mole(vecs[i].kind, vecs[i].hit_at, e);
            $display("[TB] vec %0d kind=%0d hit_at=%0d score=%0d misses=%0d over=%0d",
                     i, vecs[i].kind, vecs[i].hit_at, score, misses, game_over);
        end

        // Asynchronous reset in the middle of an UP phase with score 2
        wait_mole();
        repeat (2) @(negedge cin);
        check("pre_reset_score", int'(score), 2);
        check("pre_reset_led_on", int'(mole_led != '0), 1);
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        prev_hole = 0;
        last_act = 0;
        @(negedge cin);
        rst_n = 1'b1;
        @(negedge cin);
        check("score_inc_pulses", pulses, exp_pulses);
        $display("[TB] async reset applied, score_inc pulses=%0d", pulses);

        // 50 moles over back-to-back rounds: holes follow the LFSR and never repeat
        for (int m = 0; m < 50; m++) begin
            if (m % RM == 0) pulse_start();
            wait_mole();
            e = '{1, (m % RM) + 1, 0, 1'b1, (m % RM) == RM - 1};
            run_mole(1, 1, e);
            $display("[TB] run mole %0d hole=%0d score=%0d", m, last_act, score);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
